// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder
//   Kogge-Stone parallel-prefix adder/subtractor with a valid/ready pipeline.
//   {c_out,sum} = a + (b ^ {WIDTH{sub}}) + (c_in ^ sub)
//   Stage 1 registers the bitwise g/p terms. Later register boundaries split
//   the log2(WIDTH) prefix levels evenly. The final XOR feeds the output
//   register. All stages advance together when !out_valid || out_ready.
// Parameters: WIDTH (8/16/32/64), STAGES (1..log2(WIDTH)+1)
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready is combinational)
//   a, b, c_in, sub     operands, carry/borrow in, 0=add 1=subtract
//   out_valid/out_ready result handshake
//   sum, c_out          registered result and carry out of bit WIDTH-1
//   ovf                 signed overflow, present only with PREFIX_ADDER_OVF_EN
module pipelined_prefix_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef PREFIX_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int unsigned LVLS = $clog2(WIDTH);

    // True when a register boundary follows prefix position n (0 = bitwise g/p).
    function automatic bit f_is_reg(input int unsigned n);
        if (STAGES < 2) return 1'b0;
        if (n == 0) return 1'b1;
        for (int unsigned j = 1; j < STAGES - 1; j++) begin
            if ((j * LVLS) / (STAGES - 1) == n) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One Kogge-Stone level with span d; returns {g, p}.
    function automatic logic [2*WIDTH-1:0] f_ks_level(input logic [WIDTH-1:0] g,
                                                      input logic [WIDTH-1:0] p,
                                                      input int unsigned d);
        logic [WIDTH-1:0] go;
        logic [WIDTH-1:0] po;
        go = g;
        po = p;
        for (int unsigned i = d; i < WIDTH; i++) begin
            go[i] = g[i] | (p[i] & g[i-d]);
            po[i] = p[i] & p[i-d];
        end
        return {go, po};
    endfunction

    logic             w_adv;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_ci_eff;
    logic [WIDTH-1:0] w_carry;
    logic             w_unused_p;

    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_b_eff  = b ^ {WIDTH{sub}};
    assign w_ci_eff = c_in ^ sub;

    for (genvar n = 0; n <= LVLS; n++) begin : g_pos
        logic [WIDTH-1:0] w_g, w_p, w_h;
        logic             w_ci, w_v;
        logic [WIDTH-1:0] w_g_q, w_p_q, w_h_q;
        logic             w_ci_q, w_v_q;

        if (n == 0) begin : g_bitwise
            // Carry in is folded into bit 0 generate so group g[i] is carry out of bit i.
            assign w_h  = a ^ w_b_eff;
            assign w_p  = a ^ w_b_eff;
            assign w_g  = (a & w_b_eff) | {{(WIDTH-1){1'b0}}, (a[0] ^ w_b_eff[0]) & w_ci_eff};
            assign w_ci = w_ci_eff;
            assign w_v  = in_valid;
        end else begin : g_level
            logic [2*WIDTH-1:0] w_gp;
            assign w_gp = f_ks_level(g_pos[n-1].w_g_q, g_pos[n-1].w_p_q, 32'(1) << (n - 1));
            assign w_g  = w_gp[2*WIDTH-1:WIDTH];
            assign w_p  = w_gp[WIDTH-1:0];
            assign w_h  = g_pos[n-1].w_h_q;
            assign w_ci = g_pos[n-1].w_ci_q;
            assign w_v  = g_pos[n-1].w_v_q;
        end

        if (f_is_reg(32'(n))) begin : g_reg
            logic [WIDTH-1:0] r_g, r_p, r_h;
            logic             r_ci, r_v;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_g  <= '0;
                    r_p  <= '0;
                    r_h  <= '0;
                    r_ci <= 1'b0;
                    r_v  <= 1'b0;
                end else if (w_adv) begin
                    r_g  <= w_g;
                    r_p  <= w_p;
                    r_h  <= w_h;
                    r_ci <= w_ci;
                    r_v  <= w_v;
                end
            end
            assign w_g_q  = r_g;
            assign w_p_q  = r_p;
            assign w_h_q  = r_h;
            assign w_ci_q = r_ci;
            assign w_v_q  = r_v;
        end else begin : g_wire
            assign w_g_q  = w_g;
            assign w_p_q  = w_p;
            assign w_h_q  = w_h;
            assign w_ci_q = w_ci;
            assign w_v_q  = w_v;
        end
    end

    // Carry into bit i is the group generate of bits i-1..0, or c_in for bit 0.
    assign w_carry    = {g_pos[LVLS].w_g_q[WIDTH-2:0], g_pos[LVLS].w_ci_q};
    assign w_unused_p = ^g_pos[LVLS].w_p_q;

    // Output register: final XOR result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_c_out     <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= g_pos[LVLS].w_v_q;
            r_sum       <= g_pos[LVLS].w_h_q ^ w_carry;
            r_c_out     <= g_pos[LVLS].w_g_q[WIDTH-1];
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign c_out     = r_c_out;

`ifdef PREFIX_ADDER_OVF_EN
    logic r_ovf;
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= g_pos[LVLS].w_g_q[WIDTH-1] ^ g_pos[LVLS].w_g_q[WIDTH-2];
        end
    end
    assign ovf = r_ovf;
`endif

endmodule
